// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared FSM states, slot constants and sizing helpers for the SRAM slot arbiter
package sram_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int VID_SLOT = 0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Latest slot at which a grant still completes before the next video slot.
    function automatic int last_grant_pos(input int slot_period, input int access_cycles);
        return slot_period - 1 - access_cycles;
    endfunction

endpackage

// File: rtl/sram_arb_grant.sv
// rtl/sram_arb_grant.sv - request vector to one-hot grant; round-robin when SRAM_ARB_RR_EN is defined
module sram_arb_grant
    import sram_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = (NUM_MASTERS > 1) ? clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req,
`ifdef SRAM_ARB_RR_EN
    input  logic [IDX_W-1:0]       rr,
`endif
    output logic [NUM_MASTERS-1:0] gnt_oh,
    output logic [IDX_W-1:0]       gnt_idx
);

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
`ifdef SRAM_ARB_RR_EN
        // Walk backwards so the candidate nearest after rr is the last one written.
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (req[(int'(rr) + k) % NUM_MASTERS]) begin
                gnt_oh  = '0;
                gnt_oh[(int'(rr) + k) % NUM_MASTERS] = 1'b1;
                gnt_idx = IDX_W'((int'(rr) + k) % NUM_MASTERS);
            end
        end
`else
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_oh    = '0;
                gnt_oh[i] = 1'b1;
                gnt_idx   = IDX_W'(i);
            end
        end
`endif
    end

endmodule

// File: rtl/sram_slot_arbiter.sv
// rtl/sram_slot_arbiter.sv - N-master SRAM arbiter with fixed video slot; SRAM_ARB_RR_EN selects round-robin
module sram_slot_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_MASTERS   = 2,
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 16,
    parameter int SLOT_PERIOD   = 16,
    parameter int ACCESS_CYCLES = 2,
    localparam int SLOT_W       = clog2(SLOT_PERIOD)
) (
    input  logic                          clk25,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS*2-1:0]      m_be,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [DATA_W-1:0]             m_rdata,
    input  logic [ADDR_W-1:0]             vid_addr,
    output logic [DATA_W-1:0]             vid_data,
    output logic                          vid_valid,
    output logic [SLOT_W-1:0]             slot_pos,
    output logic [ADDR_W-1:0]             ram_addr,
    input  logic [DATA_W-1:0]             ram_dq_i,
    output logic [DATA_W-1:0]             ram_dq_o,
    output logic                          ram_dq_oe,
    output logic                          ram_ce_n,
    output logic                          ram_oe_n,
    output logic                          ram_we_n,
    output logic                          ram_lb_n,
    output logic                          ram_ub_n
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = clog2(ACCESS_CYCLES);
    localparam logic [SLOT_W-1:0] VID_POS  = SLOT_W'(VID_SLOT);
    localparam logic [SLOT_W-1:0] LAST_GNT = SLOT_W'(last_grant_pos(SLOT_PERIOD, ACCESS_CYCLES));
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic                   vid_en;
    logic [ADDR_W-1:0]      addr_l;
    logic [DATA_W-1:0]      wdata_l;
    logic [1:0]             be_l;
    logic                   we_l;
    logic [NUM_MASTERS-1:0] ack_oh;
    logic [NUM_MASTERS-1:0] gnt_oh;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   in_window;
    logic                   video_slot;
    logic                   acc;
`ifdef SRAM_ARB_RR_EN
    logic [IDX_W-1:0]       rr;
`endif

    sram_arb_grant #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_grant (
        .req     (m_req),
`ifdef SRAM_ARB_RR_EN
        .rr      (rr),
`endif
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx)
    );

    // vid_en keeps the SRAM strobes quiet during reset, which also parks slot_pos at 0.
    assign video_slot = vid_en && (slot_pos == VID_POS);
    assign acc        = (state == ST_ACCESS);
    assign in_window  = (slot_pos != VID_POS) && (slot_pos <= LAST_GNT);

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            slot_pos  <= '0;
            state     <= ST_IDLE;
            cnt       <= '0;
            vid_en    <= 1'b0;
            vid_data  <= '0;
            vid_valid <= 1'b0;
            m_rdata   <= '0;
            addr_l    <= '0;
            wdata_l   <= '0;
            be_l      <= '0;
            we_l      <= 1'b0;
            ack_oh    <= '0;
`ifdef SRAM_ARB_RR_EN
            rr        <= '0;
`endif
        end else begin
            slot_pos  <= slot_pos + 1'b1;
            vid_en    <= 1'b1;
            vid_valid <= video_slot;
            if (video_slot) vid_data <= ram_dq_i;
            case (state)
                ST_IDLE: begin
                    if (in_window && (|gnt_oh)) begin
                        addr_l  <= m_addr[gnt_idx*ADDR_W +: ADDR_W];
                        wdata_l <= m_wdata[gnt_idx*DATA_W +: DATA_W];
                        be_l    <= m_be[gnt_idx*2 +: 2];
                        we_l    <= m_we[gnt_idx];
                        ack_oh  <= gnt_oh;
                        cnt     <= '0;
                        state   <= ST_ACCESS;
`ifdef SRAM_ARB_RR_EN
                        rr      <= gnt_idx;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (cnt == LAST_CNT) begin
                        if (!we_l) m_rdata <= ram_dq_i;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The final write cycle keeps data driven with we_n high for hold time.
    always_comb begin
        ram_addr  = video_slot ? vid_addr : (acc ? addr_l : '0);
        ram_oe_n  = ~(video_slot || (acc && !we_l));
        ram_we_n  = ~(acc && we_l && (cnt != LAST_CNT));
        ram_lb_n  = video_slot ? 1'b0 : (acc ? ~be_l[0] : 1'b1);
        ram_ub_n  = video_slot ? 1'b0 : (acc ? ~be_l[1] : 1'b1);
        ram_dq_oe = acc && we_l;
        ram_dq_o  = wdata_l;
        ram_ce_n  = 1'b0;
        m_ack     = (state == ST_DONE) ? ack_oh : '0;
    end

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// tb/tb_sram_slot_arbiter.sv - directed self-checking bench for sram_slot_arbiter with an SRAM model
module tb_sram_slot_arbiter;

    logic        clk25 = 1'b0;
    logic        reset_n;
    logic [1:0]  m_req, m_we;
    logic [35:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [1:0]  m_ack;
    logic [15:0] m_rdata;
    logic [17:0] vid_addr;
    logic [15:0] vid_data;
    logic        vid_valid;
    logic [3:0]  slot_pos;
    logic [17:0] ram_addr;
    logic [15:0] ram_dq_i, ram_dq_o;
    logic        ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0] mem [0:8191];
    logic        mem_ready = 1'b0;

    sram_slot_arbiter dut (
        .clk25     (clk25),
        .reset_n   (reset_n),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_be      (m_be),
        .m_ack     (m_ack),
        .m_rdata   (m_rdata),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .slot_pos  (slot_pos),
        .ram_addr  (ram_addr),
        .ram_dq_i  (ram_dq_i),
        .ram_dq_o  (ram_dq_o),
        .ram_dq_oe (ram_dq_oe),
        .ram_ce_n  (ram_ce_n),
        .ram_oe_n  (ram_oe_n),
        .ram_we_n  (ram_we_n),
        .ram_lb_n  (ram_lb_n),
        .ram_ub_n  (ram_ub_n)
    );

    always #20 clk25 = ~clk25;

    assign ram_dq_i = (!ram_oe_n && !ram_ce_n) ? mem[ram_addr[12:0]] : 16'h0000;

    always @(posedge clk25) begin
        if (!mem_ready) begin
            for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
            mem[13'h1000] = 16'hA5A5;
            mem_ready = 1'b1;
        end else if (!ram_we_n && !ram_ce_n && ram_dq_oe) begin
            if (!ram_lb_n) mem[ram_addr[12:0]][7:0]  = ram_dq_o[7:0];
            if (!ram_ub_n) mem[ram_addr[12:0]][15:8] = ram_dq_o[15:8];
        end
    end

    task automatic step();
        @(posedge clk25);
        @(negedge clk25);
        cyc++;
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 32 && (cyc % 16) != s; i++) step();
    endtask

    task automatic set_master(input int m, input logic we, input logic [17:0] a,
                              input logic [15:0] d, input logic [1:0] be);
        m_we[m]           = we;
        m_addr[m*18 +: 18] = a;
        m_wdata[m*16 +: 16] = d;
        m_be[m*2 +: 2]     = be;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_be = '0;
        vid_addr = 18'h01000;
        @(negedge clk25);
        @(negedge clk25);
        checks++;
        if (slot_pos !== 4'd0 || m_ack !== 2'b00 || m_rdata !== 16'h0 || vid_data !== 16'h0 || vid_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_core: slot=%0d ack=%b rdata=%h vdata=%h vvalid=%b expected 0 0 0000 0000 0", slot_pos, m_ack, m_rdata, vid_data, vid_valid);
        end
        checks++;
        if ({ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n, ram_ce_n, ram_dq_oe} !== 6'b111100 || ram_addr !== 18'h0) begin
            errors++;
            $display("FAIL reset_strobes: oe/we/lb/ub/ce/dqoe=%b addr=%h expected 111100 00000", {ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n, ram_ce_n, ram_dq_oe}, ram_addr);
        end
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_video();
        for (int i = 0; i < 36; i++) begin
            step();
            checks++;
            if (slot_pos !== 4'(cyc % 16) || ram_we_n !== 1'b1) begin
                errors++;
                $display("FAIL video_slotpos: slot=%0d we_n=%b expected %0d 1", slot_pos, ram_we_n, cyc % 16);
            end
            checks++;
            if (vid_valid !== ((cyc % 16 == 1) && cyc > 1)) begin
                errors++;
                $display("FAIL video_valid: cyc=%0d got %b expected %b", cyc, vid_valid, (cyc % 16 == 1) && cyc > 1);
            end
            if (cyc % 16 == 1 && cyc > 1) begin
                checks++;
                if (vid_data !== 16'hA5A5) begin
                    errors++;
                    $display("FAIL video_data: got %h expected a5a5", vid_data);
                end
            end
            if (cyc % 16 == 0) begin
                checks++;
                if (ram_oe_n !== 1'b0 || ram_addr !== 18'h01000 || ram_dq_oe !== 1'b0 || ram_lb_n !== 1'b0) begin
                    errors++;
                    $display("FAIL video_strobes: oe_n=%b addr=%h dq_oe=%b lb_n=%b expected 0 01000 0 0", ram_oe_n, ram_addr, ram_dq_oe, ram_lb_n);
                end
            end
        end
    endtask

    task automatic test_write();
        wait_slot(2);
        set_master(0, 1'b1, 18'h00200, 16'h1234, 2'b11);
        m_req[0] = 1'b1;
        step();
        checks++;
        if (ram_we_n !== 1'b0 || ram_dq_oe !== 1'b1 || ram_addr !== 18'h00200 || ram_dq_o !== 16'h1234) begin
            errors++;
            $display("FAIL write_c0: we_n=%b dq_oe=%b addr=%h dq=%h expected 0 1 00200 1234", ram_we_n, ram_dq_oe, ram_addr, ram_dq_o);
        end
        step();
        checks++;
        if (ram_we_n !== 1'b1 || ram_dq_oe !== 1'b1 || m_ack !== 2'b00) begin
            errors++;
            $display("FAIL write_c1: we_n=%b dq_oe=%b ack=%b expected 1 1 00", ram_we_n, ram_dq_oe, m_ack);
        end
        step();
        checks++;
        if (m_ack !== 2'b01 || ram_dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL write_ack: ack=%b dq_oe=%b expected 01 0", m_ack, ram_dq_oe);
        end
        m_req[0] = 1'b0;
        step();
        checks++;
        if (m_ack !== 2'b00 || mem[13'h0200] !== 16'h1234) begin
            errors++;
            $display("FAIL write_mem: ack=%b mem=%h expected 00 1234", m_ack, mem[13'h0200]);
        end
    endtask

    task automatic test_read_lane();
        wait_slot(3);
        set_master(1, 1'b0, 18'h00200, 16'h0000, 2'b01);
        m_req[1] = 1'b1;
        step();
        checks++;
        if (ram_ub_n !== 1'b1 || ram_lb_n !== 1'b0 || ram_oe_n !== 1'b0 || ram_dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL read_lanes: ub_n=%b lb_n=%b oe_n=%b dq_oe=%b expected 1 0 0 0", ram_ub_n, ram_lb_n, ram_oe_n, ram_dq_oe);
        end
        step();
        step();
        checks++;
        if (m_ack !== 2'b10 || m_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL read_ack: ack=%b rdata=%h expected 10 1234", m_ack, m_rdata);
        end
        m_req[1] = 1'b0;
        step();
    endtask

    task automatic test_window();
        set_master(0, 1'b0, 18'h00200, 16'h0000, 2'b11);
        mem[13'h0200] = 16'h5A3C;
        wait_slot(14);
        m_req[0] = 1'b1;
        step();
        checks++;
        if (ram_oe_n !== 1'b1 || ram_addr !== 18'h0) begin
            errors++;
            $display("FAIL window_s15: oe_n=%b addr=%h expected 1 00000", ram_oe_n, ram_addr);
        end
        step();
        checks++;
        if (ram_oe_n !== 1'b0 || ram_addr !== 18'h01000 || ram_dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL window_s0: oe_n=%b addr=%h dq_oe=%b expected 0 01000 0", ram_oe_n, ram_addr, ram_dq_oe);
        end
        step();
        checks++;
        if (ram_oe_n !== 1'b1 || vid_valid !== 1'b1 || vid_data !== 16'hA5A5) begin
            errors++;
            $display("FAIL window_s1: oe_n=%b vvalid=%b vdata=%h expected 1 1 a5a5", ram_oe_n, vid_valid, vid_data);
        end
        step();
        checks++;
        if (ram_addr !== 18'h00200 || ram_oe_n !== 1'b0) begin
            errors++;
            $display("FAIL window_s2: addr=%h oe_n=%b expected 00200 0", ram_addr, ram_oe_n);
        end
        step();
        step();
        checks++;
        if (m_ack !== 2'b01 || m_rdata !== 16'h5A3C) begin
            errors++;
            $display("FAIL window_ack: ack=%b rdata=%h expected 01 5a3c", m_ack, m_rdata);
        end
        m_req[0] = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int acks;
        int last;
        int exp;
        acks = 0;
        last = 0;
        set_master(0, 1'b0, 18'h00200, 16'h0000, 2'b11);
        set_master(1, 1'b0, 18'h00200, 16'h0000, 2'b11);
        m_req = 2'b11;
        for (int i = 0; i < 400 && acks < 8; i++) begin
            step();
            if (m_ack !== 2'b00) begin
`ifdef SRAM_ARB_RR_EN
                exp = (last == 0) ? 1 : 0;
`else
                exp = 0;
`endif
                checks++;
                if (m_ack !== (2'b01 << exp)) begin
                    errors++;
                    $display("FAIL b2b_winner: ack #%0d got %b expected %b", acks, m_ack, 2'b01 << exp);
                end
                last = (m_ack == 2'b10) ? 1 : 0;
                acks++;
            end
        end
        m_req = 2'b00;
        checks++;
        if (acks != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d acks expected 8", acks);
        end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        wait_slot(2);
        set_master(0, 1'b1, 18'h00300, 16'hBEEF, 2'b11);
        m_req[0] = 1'b1;
        step();
        checks++;
        if (ram_we_n !== 1'b0) begin
            errors++;
            $display("FAIL midrst_active: we_n=%b expected 0", ram_we_n);
        end
        #5 reset_n = 1'b0;
        #1;
        checks++;
        if (ram_we_n !== 1'b1 || ram_dq_oe !== 1'b0 || ram_oe_n !== 1'b1 || slot_pos !== 4'd0 || m_ack !== 2'b00) begin
            errors++;
            $display("FAIL midrst_abort: we_n=%b dq_oe=%b oe_n=%b slot=%0d ack=%b expected 1 0 1 0 00", ram_we_n, ram_dq_oe, ram_oe_n, slot_pos, m_ack);
        end
        m_req[0] = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        cyc = 0;
        checks++;
        if (slot_pos !== 4'd0 || m_ack !== 2'b00) begin
            errors++;
            $display("FAIL midrst_release: slot=%0d ack=%b expected 0 00", slot_pos, m_ack);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (m_ack !== 2'b00 || slot_pos !== 4'(cyc)) begin
                errors++;
                $display("FAIL midrst_after: ack=%b slot=%0d expected 00 %0d", m_ack, slot_pos, cyc);
            end
        end
        checks++;
        if (mem[13'h0300] !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_mem: got %h expected 0000", mem[13'h0300]);
        end
    endtask

    initial begin
        test_reset();
        test_video();
        test_write();
        test_read_lane();
        test_window();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_slot_arbiter.md
Name: sram_slot_arbiter

Overview:
- Parametrised arbiter for the shared 16-bit asynchronous SRAM. Generalises the fixed CPU/JTAG/video priority mux into N request/acknowledge masters plus one deterministic video fetch slot.
- Video always owns slot 0 of every SLOT_PERIOD-cycle frame. Master accesses are scheduled so they never overlap that slot.
- Sits between bkcore, the JTAG/host port and the pixel shifter on one side, and the SRAM pins on the other.

Parameters:
- NUM_MASTERS, 2: number of request ports; index 0 is highest fixed priority.
- ADDR_W, 18: SRAM word address width.
- DATA_W, 16: data width; always two byte lanes.
- SLOT_PERIOD, 16: cycles per video frame slot. Must be a power of two and >= ACCESS_CYCLES+2.
- ACCESS_CYCLES, 2: SRAM cycles per master access; minimum 2.

Ports:
- clk25  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- m_req  in  NUM_MASTERS  per-master request; held high until m_ack.
- m_we  in  NUM_MASTERS  1=write, 0=read.
- m_addr  in  NUM_MASTERS*ADDR_W  word addresses, master i at bits [i*ADDR_W +: ADDR_W].
- m_wdata  in  NUM_MASTERS*DATA_W  write data, packed the same way.
- m_be  in  NUM_MASTERS*2  byte enables, bit0 = low byte.
- m_ack  out  NUM_MASTERS  one-cycle completion pulse, one-hot.
- m_rdata  out  DATA_W  read data of the last completed read.
- vid_addr  in  ADDR_W  video fetch address, sampled at slot 0.
- vid_data  out  DATA_W  fetched video word.
- vid_valid  out  1  one-cycle pulse when vid_data updates; drives the shifter load.
- slot_pos  out  log2(SLOT_PERIOD)  current slot counter value.
- ram_addr  out  ADDR_W  SRAM address.
- ram_dq_i  in  DATA_W  SRAM data in.
- ram_dq_o  out  DATA_W  SRAM data out.
- ram_dq_oe  out  1  tristate enable for ram_dq_o.
- ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n  out  1 each  SRAM strobes, active low.

Behaviour:
- Reset, asynchronous while reset_n=0:
  - slot_pos=0, FSM=IDLE, rr pointer=0.
  - m_ack=0, m_rdata=0, vid_data=0, vid_valid=0.
  - ram_oe_n=ram_we_n=ram_lb_n=ram_ub_n=1, ram_ce_n=0, ram_dq_oe=0, ram_addr=0.
- Reset mid-access aborts the access immediately with no ack; the master re-requests.
- slot_pos increments every clk25 and wraps from SLOT_PERIOD-1 to 0.
- Video slot (slot_pos==0), owned unconditionally:
  - ram_addr=vid_addr, ram_oe_n=0, lb_n=ub_n=0, dq_oe=0.
  - Next edge registers vid_data=ram_dq_i; vid_valid=1 while slot_pos==1.
- Grant window: a master may be granted only in IDLE and when 1 <= slot_pos <= SLOT_PERIOD-1-ACCESS_CYCLES. The whole access therefore finishes before the next slot 0.
- FSM states:
  - IDLE: on any m_req in the window, pick winner g (fixed priority: lowest index). Latch addr, wdata, be, we, g. Go to ACCESS with count=0.
  - ACCESS: lasts ACCESS_CYCLES cycles.
    - ram_addr=latched addr; lb_n/ub_n = ~be.
    - Read: oe_n=0 on all cycles; on the last-cycle edge, m_rdata<=ram_dq_i.
    - Write: dq_oe=1 and ram_dq_o=wdata on all cycles; we_n=0 on all but the last cycle, which provides data hold.
    - Then go to DONE.
  - DONE: m_ack[g]=1 for one cycle, m_rdata valid in this cycle, go to IDLE.
- Latency: grant at edge T, ack visible in cycle T+ACCESS_CYCLES+1. Minimum 3 cycles between grants to the same master.
- Master protocol:
  - req must stay high with stable addr/data/be/we until ack.
  - req still high in the cycle after ack counts as a new request.
  - Dropping req before ack after a grant is illegal; the access completes anyway.
- Simultaneous requests: only one grant per IDLE cycle; losers wait with no starvation guarantee in fixed mode.
- m_be=2'b00 performs a bus cycle with both lanes disabled and is still acked.
- Outside the video slot and ACCESS, strobes are inactive and dq_oe=0.

Optional Feature:
- SRAM_ARB_RR_EN defined: round-robin grant. The search starts at rr+1 modulo NUM_MASTERS; rr<=g on each grant. Any continuously requesting master is granted within NUM_MASTERS grants.
- Undefined: fixed priority, lowest index wins; the rr register is absent.

Decomposition:
- Shared package sram_arb_pkg:
  - FSM state enum {IDLE, ACCESS, DONE}.
  - Slot constant VID_SLOT=0.
  - Function clog2.
  - Helper for the last legal grant position.
- One sub-module, sram_arb_grant: combinational request vector plus rr pointer to one-hot grant and index. It contains the fixed/RR selection under the macro.

Test Plan:
- Reset release, no requests, vid_addr=18'h1000, ram_dq_i=16'hA5A5 -> vid_valid pulses at slot_pos==1 every 16 cycles, vid_data=16'hA5A5, ram_we_n stays 1.
- Master 0 write addr=18'h00200, wdata=16'h1234, be=2'b11, requested at slot_pos=2 -> ram_we_n low 1 cycle, dq_oe high 2 cycles, m_ack[0] 3 cycles after grant; SRAM model holds 16'h1234.
- Master 1 read of 18'h00200 with be=2'b01 -> ram_ub_n=1, ram_lb_n=0, m_rdata=16'h1234 in the m_ack[1] cycle.
- Request raised at slot_pos=14 (SLOT_PERIOD=16, ACCESS_CYCLES=2) -> no grant until slot_pos=1; slot 0 video read is undisturbed.
- Masters 0 and 1 both hold req for 8 accesses -> fixed mode: 8 acks to master 0, none to 1. With SRAM_ARB_RR_EN: acks alternate 0,1,0,1.
- reset_n asserted mid-ACCESS of a write -> strobes inactive immediately, no m_ack; after release slot_pos restarts at 0.
